pend_encoder_32x5: RTL and testbench
====================================

// Module: pend_encoder_32x5
// PURPOSE
//  Sequential 32-to-5 encoder: the encode-side counterpart of the 5x32 line decoder.
//  Collects one-hot/multi-hot event strobes into a 32-bit pending register.
//  Presents one pending bit at a time as a 5-bit index on a valid/ready output stage.
//  Used for register-select, interrupt and event-source encoding.
// PARAMETERS
//  PEND_INIT    32'h00000000  reset value of pending register (bit i=1 -> preset)
//  ROUND_ROBIN  0             0: lowest index first; 1: rotating search from PTR
// PORTS
//  CLK        in   1   clock, +ve edge
//  RESET      in   1   async active-low reset (RESET=0 resets)
//  SET        in   32  event strobes; bit i=1 marks source i pending
//  CLEAR      in   1   sync flush of pending reg and output stage
//  OUT_READY  in   1   consumer accepts INDEX this cycle
//  OUT_VALID  out  1   INDEX holds a granted source
//  INDEX      out  5   encoded source number, 0..31
//  PENDING    out  32  current pending register (not yet granted)
//  PTR        out  5   round-robin search start; held 0 when ROUND_ROBIN=0
// BEHAVIOUR
//  Reset (async, RESET=0): PENDING=PEND_INIT, OUT_VALID=0, INDEX=0, PTR=0.
//  State: pending reg P[31:0]; output stage {OUT_VALID, INDEX}; pointer PTR.
//  Output stage states: EMPTY (OUT_VALID=0), FULL (OUT_VALID=1).
//  take = OUT_VALID & OUT_READY; load_ok = ~OUT_VALID | take.
//  Search: first set bit of P scanning upward from base (0, or PTR if ROUND_ROBIN),
//   wrapping 31->0; sel = that index; found = |P.
//  Per edge (CLEAR=0):
//   - load_ok & found: INDEX<=sel, OUT_VALID<=1, P[sel] cleared.
//   - load_ok & ~found: OUT_VALID<=0, INDEX holds.
//   - ~load_ok: OUT_VALID, INDEX held stable (no change while stalled).
//   - P <= (P & ~clrmask) | SET; SET wins over the clear of the bit being loaded
//     (source stays pending; a repeat event is not lost).
//   - ROUND_ROBIN=1 and load: PTR<=sel+1 mod 32 (31 -> 0).
//  CLEAR=1 (highest priority, sync): P<=0, OUT_VALID<=0, PTR<=0; SET ignored.
//  Latency: SET sampled at edge k -> OUT_VALID=1 after edge k+1 when stage free.
//  Throughput: one index per cycle with OUT_READY held high.
//  Repeated SET of an already-pending bit merges (no count); width is fixed at 32.
//  INDEX is 5-bit unsigned; no out-of-range values possible.
//  Reset mid-operation: all state returns to reset values immediately; no grant survives.
// TESTING
//  1. Reset with PEND_INIT=32'h80000001 -> PENDING=80000001, OUT_VALID=0; release
//     RESET, OUT_READY=1 -> INDEX 0 then 31 on successive cycles, then OUT_VALID=0.
//  2. SET=32'h00010410 one cycle, OUT_READY=1, fixed mode -> INDEX 4,10,16 back-to-back.
//  3. SET=32'h0000000F, OUT_READY=0 for 5 cycles -> INDEX=0 held, PENDING=0000000E;
//     raise OUT_READY -> 1,2,3 follow.
//  4. ROUND_ROBIN=1: grant 31, then SET bits 0 and 30 -> next INDEX=0 (PTR wrapped),
//     then 30.
//  5. SET[5]=1 on the same edge that bit 5 is loaded -> INDEX=5, PENDING[5]=1 after
//     the edge; next grant is INDEX=5 again.
//  6. CLEAR=1 with SET=FFFFFFFF and OUT_VALID=1 -> PENDING=0, OUT_VALID=0; async
//     RESET pulse mid-stream -> outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/pend_encoder_32x5.sv
// pend_encoder_32x5: sequential 32-to-5 event encoder.
// Pending register feeding a one-entry valid/ready index stage.
module pend_encoder_32x5 #(
  parameter logic [31:0] PEND_INIT   = 32'h0000_0000,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] SET,
  input  logic        CLEAR,
  input  logic        OUT_READY,
  output logic        OUT_VALID,
  output logic [4:0]  INDEX,
  output logic [31:0] PENDING,
  output logic [4:0]  PTR
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_e;

  stage_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [4:0]  index_q, index_d;
  logic [4:0]  ptr_q, ptr_d;

  logic        take;
  logic        load_ok;
  logic        found;
  logic [4:0]  base;
  logic [4:0]  off;
  logic [4:0]  sel;
  logic [63:0] dbl;
  logic [31:0] rot;
  logic [31:0] clrmask;

  assign take    = (state_q == FULL) & OUT_READY;
  assign load_ok = (state_q == EMPTY) | take;
  assign found   = |pend_q;
  assign base    = ROUND_ROBIN ? ptr_q : 5'd0;

  // Rotate so the search base sits at bit 0, then pick the lowest set bit.
  always_comb begin
    dbl = {pend_q, pend_q} >> base;
    rot = dbl[31:0];
    off = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (rot[i]) off = i[4:0];
    end
    sel = off + base;
  end

  // Next state: flush first, then load/stall; new events always merge in.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    clrmask = '0;
    pend_d  = pend_q | SET;
    if (CLEAR) begin
      state_d = EMPTY;
      ptr_d   = 5'd0;
      pend_d  = '0;
    end else if (load_ok && found) begin
      state_d = FULL;
      index_d = sel;
      clrmask = 32'd1 << sel;
      if (ROUND_ROBIN) ptr_d = sel + 5'd1;
      pend_d  = (pend_q & ~clrmask) | SET;
    end else if (load_ok) begin
      state_d = EMPTY;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= EMPTY;
      pend_q  <= PEND_INIT;
      index_q <= 5'd0;
      ptr_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
    end
  end

  assign OUT_VALID = (state_q == FULL);
  assign INDEX     = index_q;
  assign PENDING   = pend_q;
  assign PTR       = ptr_q;

endmodule

// File: tb/tb_pend_encoder_32x5.sv
// tb_pend_encoder_32x5: vector table, directed corners and random
// traffic for a fixed-priority and a round-robin instance.
module tb_pend_encoder_32x5;

  logic        CLK;
  logic        RESET;
  logic [31:0] SET;
  logic        CLEAR;
  logic        OUT_READY;

  logic        f_valid, r_valid;
  logic [4:0]  f_index, r_index;
  logic [31:0] f_pend, r_pend;
  logic [4:0]  f_ptr, r_ptr;

  int n_chk  = 0;
  int n_pass = 0;

  pend_encoder_32x5 #(
    .PEND_INIT  (32'h8000_0001),
    .ROUND_ROBIN(1'b0)
  ) u_fix (
    .CLK      (CLK),
    .RESET    (RESET),
    .SET      (SET),
    .CLEAR    (CLEAR),
    .OUT_READY(OUT_READY),
    .OUT_VALID(f_valid),
    .INDEX    (f_index),
    .PENDING  (f_pend),
    .PTR      (f_ptr)
  );

  pend_encoder_32x5 #(
    .PEND_INIT  (32'h0000_0000),
    .ROUND_ROBIN(1'b1)
  ) u_rr (
    .CLK      (CLK),
    .RESET    (RESET),
    .SET      (SET),
    .CLEAR    (CLEAR),
    .OUT_READY(OUT_READY),
    .OUT_VALID(r_valid),
    .INDEX    (r_index),
    .PENDING  (r_pend),
    .PTR      (r_ptr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: instance 0 fixed priority, instance 1 rotating.
  logic [31:0] m_p   [2];
  bit          m_v   [2];
  int          m_i   [2];
  int          m_ptr [2];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_p[0] = 32'h8000_0001;
    m_p[1] = 32'h0;
    for (int d = 0; d < 2; d++) begin
      m_v[d]   = 1'b0;
      m_i[d]   = 0;
      m_ptr[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    bit          ld;
    int          base;
    int          sel;
    logic [31:0] np;
    if (CLEAR) begin
      m_p[d]   = 32'h0;
      m_v[d]   = 1'b0;
      m_ptr[d] = 0;
      return;
    end
    ld   = !m_v[d] || OUT_READY;
    base = (d == 1) ? m_ptr[d] : 0;
    sel  = -1;
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (base + k) % 32;
      if (sel < 0 && m_p[d][j]) sel = j;
    end
    np = m_p[d];
    if (ld && sel >= 0) begin
      np[sel] = 1'b0;
      m_i[d]  = sel;
      m_v[d]  = 1'b1;
      if (d == 1) m_ptr[d] = (sel + 1) % 32;
    end else if (ld) begin
      m_v[d] = 1'b0;
    end
    m_p[d] = np | SET;
  endtask

  task automatic cmp_model();
    check("fix_valid", 32'(f_valid), 32'(m_v[0]));
    check("fix_index", 32'(f_index), 32'(m_i[0]));
    check("fix_pend",  f_pend,       m_p[0]);
    check("fix_ptr",   32'(f_ptr),   32'(m_ptr[0]));
    check("rr_valid",  32'(r_valid), 32'(m_v[1]));
    check("rr_index",  32'(r_index), 32'(m_i[1]));
    check("rr_pend",   r_pend,       m_p[1]);
    check("rr_ptr",    32'(r_ptr),   32'(m_ptr[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    @(negedge CLK);
    cmp_model();
  endtask

  typedef struct {
    logic [31:0] set;
    logic        clr;
    logic        rdy;
    logic        e_valid;
    logic [4:0]  e_index;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vt [25];

  initial begin
    vt[0]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd0,  32'h8000_0000};
    vt[1]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd31, 32'h0000_0000};
    vt[2]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd31, 32'h0000_0000};
    vt[3]  = '{32'h0001_0410, 1'b0, 1'b1, 1'b0, 5'd31, 32'h0001_0410};
    vt[4]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd4,  32'h0001_0400};
    vt[5]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0001_0000};
    vt[6]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd16, 32'h0000_0000};
    vt[7]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd16, 32'h0000_0000};
    vt[8]  = '{32'h0000_000F, 1'b0, 1'b0, 1'b0, 5'd16, 32'h0000_000F};
    vt[9]  = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_000E};
    vt[10] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_000E};
    vt[11] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_000E};
    vt[12] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_000E};
    vt[13] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'h0000_000E};
    vt[14] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd1,  32'h0000_000C};
    vt[15] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd2,  32'h0000_0008};
    vt[16] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd3,  32'h0000_0000};
    vt[17] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd3,  32'h0000_0000};
    vt[18] = '{32'h0000_0020, 1'b0, 1'b1, 1'b0, 5'd3,  32'h0000_0020};
    vt[19] = '{32'h0000_0020, 1'b0, 1'b1, 1'b1, 5'd5,  32'h0000_0020};
    vt[20] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd5,  32'h0000_0000};
    vt[21] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 5'd5,  32'h0000_0000};
    vt[22] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 5'd5,  32'hFFFF_FFFF};
    vt[23] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFE};
    vt[24] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000};

    RESET     = 1'b0;
    SET       = '0;
    CLEAR     = 1'b0;
    OUT_READY = 1'b0;
    model_reset();

    @(negedge CLK);
    check("rst_fix_pend",  f_pend, 32'h8000_0001);
    check("rst_fix_valid", 32'(f_valid), 32'd0);
    check("rst_fix_index", 32'(f_index), 32'd0);
    check("rst_rr_pend",   r_pend, 32'h0);
    check("rst_rr_ptr",    32'(r_ptr), 32'd0);
    RESET = 1'b1;

    for (int n = 0; n < 25; n++) begin
      SET       = vt[n].set;
      CLEAR     = vt[n].clr;
      OUT_READY = vt[n].rdy;
      cyc();
      check($sformatf("vec%0d_valid", n), 32'(f_valid), 32'(vt[n].e_valid));
      check($sformatf("vec%0d_index", n), 32'(f_index), 32'(vt[n].e_index));
      check($sformatf("vec%0d_pend", n),  f_pend,       vt[n].e_pend);
    end
    CLEAR = 1'b0;

    // Rotating search wraps past 31 to 0.
    OUT_READY = 1'b1;
    SET = 32'h8000_0000; cyc();
    SET = 32'h0;         cyc();
    check("rr_g31_index", 32'(r_index), 32'd31);
    check("rr_g31_ptr",   32'(r_ptr),   32'd0);
    SET = 32'h4000_0001; cyc();
    SET = 32'h0;         cyc();
    check("rr_wrap_index", 32'(r_index), 32'd0);
    check("rr_wrap_valid", 32'(r_valid), 32'd1);
    cyc();
    check("rr_next_index", 32'(r_index), 32'd30);
    check("rr_next_ptr",   32'(r_ptr),   32'd31);
    SET = 32'h8000_0001; cyc();
    SET = 32'h0;         cyc();
    check("rr_from31_index", 32'(r_index), 32'd31);
    check("fix_low_index",   32'(f_index), 32'd0);
    cyc();
    check("rr_after_index",  32'(r_index), 32'd0);
    check("fix_after_index", 32'(f_index), 32'd31);
    cyc();

    // Asynchronous reset pulse with grants in flight.
    SET = 32'h0000_FFFF; OUT_READY = 1'b0; cyc();
    SET = 32'h0;         cyc();
    check("pre_rst_valid", 32'(f_valid), 32'd1);
    #2 RESET = 1'b0;
    #1;
    model_reset();
    check("arst_fix_valid", 32'(f_valid), 32'd0);
    check("arst_fix_pend",  f_pend,       32'h8000_0001);
    check("arst_fix_index", 32'(f_index), 32'd0);
    check("arst_rr_valid",  32'(r_valid), 32'd0);
    check("arst_rr_pend",   r_pend,       32'h0);
    check("arst_rr_ptr",    32'(r_ptr),   32'd0);
    @(negedge CLK);
    cmp_model();
    RESET = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      SET       = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) SET = 32'h0;
      CLEAR     = ($urandom_range(0, 29) == 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
